// File: rtl/led_blink_sequencer.sv
// LED blinker: manual rate select from sw, or an 8-step auto sequence from a small pattern memory.
// Optional macro BLINK_SEQ_LOOP_EN: auto sequence wraps step 7 -> 0 instead of stopping in DONE.
module led_blink_sequencer #(
  parameter logic [31:0] BASE_DIV     = 32'd3840000000,
  parameter int unsigned HOLD_TOGGLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       mode,
  input  logic       start,
  input  logic       stop,
  input  logic       seq_we,
  input  logic [2:0] seq_addr,
  input  logic [3:0] seq_data,
  output logic       led,
  output logic       busy,
  output logic       seq_done,
  output logic [2:0] step_idx,
  output logic [3:0] cur_code
);
  typedef enum logic [1:0] {IDLE, MANUAL, RUN, DONE} state_t;
  typedef logic [15:0][31:0] per_tab_t;

  // Table holds P(c)-1 so the divider compares directly against the counter.
  function automatic per_tab_t build_tab();
    per_tab_t    t;
    logic [31:0] p;
    t[0] = '0;
    for (int c = 1; c < 16; c++) begin
      p    = BASE_DIV / 32'(c);
      t[c] = (p == 32'd0) ? 32'd0 : p - 32'd1;
    end
    return t;
  endfunction

  localparam per_tab_t        PER_M1   = build_tab();
  localparam logic [7:0]      HOLD_M1  = 8'(HOLD_TOGGLES - 1);
  localparam logic [7:0][3:0] MEM_INIT = {4'd2, 4'd4, 4'd8, 4'd15, 4'd8, 4'd4, 4'd2, 4'd1};

  state_t          state, state_nxt;
  logic [1:0][3:0] sw_sync;
  logic [7:0][3:0] mem;
  logic [3:0]      step_code, code_q;
  logic [31:0]     cnt;
  logic [7:0]      tcnt;
  logic            led_q;
  logic            step_load;
  logic [2:0]      load_idx;
  logic            code_chg, toggle, step_done;

  assign code_chg  = (cur_code != code_q);
  assign toggle    = (cur_code != 4'd0) && !code_chg && (cnt == PER_M1[cur_code]);
  assign step_done = (step_code == 4'd0) || (toggle && (tcnt == HOLD_M1));
  assign led       = led_q & (cur_code != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_load = 1'b0;
    load_idx  = step_idx;
    if (stop) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: begin
          if (!mode) state_nxt = MANUAL;
          else if (start) begin
            state_nxt = RUN;
            step_load = 1'b1;
            load_idx  = 3'd0;
          end
        end
        MANUAL: if (mode) state_nxt = IDLE;
        RUN: begin
          if (step_done) begin
            if (step_idx == 3'd7) begin
`ifdef BLINK_SEQ_LOOP_EN
              step_load = 1'b1;
              load_idx  = 3'd0;
`else
              state_nxt = DONE;
`endif
            end else begin
              step_load = 1'b1;
              load_idx  = step_idx + 3'd1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_nxt = RUN;
            step_load = 1'b1;
            load_idx  = 3'd0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    seq_done = 1'b0;
    cur_code = 4'd0;
    case (state)
      MANUAL:  cur_code = sw_sync[1];
      RUN: begin
        busy     = 1'b1;
        cur_code = step_code;
      end
      DONE:    seq_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_sync <= '0;
    else        sw_sync <= {sw_sync[0], sw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem <= MEM_INIT;
    else if (seq_we) mem[seq_addr] <= seq_data;
  end

  // Step code is latched at load, so writes to the active address wait for its next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_idx  <= '0;
      step_code <= '0;
      tcnt      <= '0;
    end else if (step_load) begin
      step_idx  <= load_idx;
      step_code <= mem[load_idx];
      tcnt      <= '0;
    end else if (state == RUN && toggle) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // A load coincides with the final toggle, so code_q tracks it to avoid a second clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      led_q  <= 1'b0;
      code_q <= '0;
    end else begin
      code_q <= step_load ? mem[load_idx] : cur_code;
      if (cur_code == 4'd0) begin
        cnt   <= '0;
        led_q <= 1'b0;
      end else if (code_chg) begin
        cnt <= '0;
      end else if (toggle) begin
        cnt   <= '0;
        led_q <= ~led_q;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with BASE_DIV=60, HOLD_TOGGLES=2.
module tb_led_blink_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, mode, start, stop, seq_we;
  logic [3:0] sw, seq_data;
  logic [2:0] seq_addr;
  logic       led, busy, seq_done;
  logic [2:0] step_idx;
  logic [3:0] cur_code;
  int tests = 0;
  int fails = 0;
  int codes [8] = '{1, 2, 4, 8, 15, 8, 4, 2};

  always #5 clk = ~clk;

  led_blink_sequencer #(.BASE_DIV(32'd60), .HOLD_TOGGLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .start(start), .stop(stop),
    .seq_we(seq_we), .seq_addr(seq_addr), .seq_data(seq_data),
    .led(led), .busy(busy), .seq_done(seq_done), .step_idx(step_idx), .cur_code(cur_code)
  );

  // Negedges until led changes; -1 if it never does.
  task automatic wait_led(output int n);
    logic prev;
    int   i;
    prev = led; i = 0; n = -1;
    while (n < 0 && i < 500) begin
      @(negedge clk); i++;
      if (led !== prev) n = i;
    end
  endtask

  // Negedges until step_idx moves or seq_done rises; -1 on timeout.
  task automatic wait_step(output int n);
    logic [2:0] prev;
    int         i;
    prev = step_idx; i = 0; n = -1;
    while (n < 0 && i < 500) begin
      @(negedge clk); i++;
      if (step_idx !== prev || seq_done === 1'b1) n = i;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; start = 1'b0; stop = 1'b0; sw = 4'd0;
    seq_we = 1'b0; seq_addr = 3'd0; seq_data = 4'd0;
    repeat (3) @(negedge clk);
    tests++; if ({led, busy, seq_done} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {led, busy, seq_done}); end
    tests++; if ({step_idx, cur_code} !== 7'd0) begin fails++; $display("FAIL reset_step_code: got idx=%0d code=%0d expected 0/0", step_idx, cur_code); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if ({busy, cur_code} !== 5'd0) begin fails++; $display("FAIL reset_idle: got busy=%b code=%0d expected 0/0", busy, cur_code); end
  endtask

  task automatic test_manual();
    int n;
    mode = 1'b0; sw = 4'b0100;
    wait_led(n);
    tests++; if (n !== 18) begin fails++; $display("FAIL manual_first: got %0d expected 18", n); end
    for (int k = 0; k < 2; k++) begin
      wait_led(n);
      tests++; if (n !== 15) begin fails++; $display("FAIL manual_p15: got %0d expected 15", n); end
    end
    tests++; if (cur_code !== 4'd4) begin fails++; $display("FAIL manual_code4: got %0d expected 4", cur_code); end
    sw = 4'b0011;
    wait_led(n);
    tests++; if (n !== 23) begin fails++; $display("FAIL manual_clear: got %0d expected 23", n); end
    wait_led(n);
    tests++; if (n !== 20) begin fails++; $display("FAIL manual_p20: got %0d expected 20", n); end
    tests++; if (cur_code !== 4'd3) begin fails++; $display("FAIL manual_code3: got %0d expected 3", cur_code); end
    mode = 1'b1;
    @(negedge clk);
    tests++; if ({led, cur_code} !== 5'd0) begin fails++; $display("FAIL manual_to_idle: got led=%b code=%0d expected 0/0", led, cur_code); end
  endtask

  task automatic test_auto_seq();
    int n;
    pulse_start();
    tests++; if ({busy, step_idx, cur_code} !== {1'b1, 3'd0, 4'd1}) begin fails++; $display("FAIL auto_start: got busy=%b idx=%0d code=%0d expected 1/0/1", busy, step_idx, cur_code); end
    for (int i = 0; i < 8; i++) begin
      wait_step(n);
      tests++; if (n !== 2 * (60 / codes[i])) begin fails++; $display("FAIL auto_step%0d_len: got %0d expected %0d", i, n, 2 * (60 / codes[i])); end
      if (i < 7) begin
        tests++; if (step_idx !== 3'(i + 1) || cur_code !== 4'(codes[i + 1])) begin fails++; $display("FAIL auto_step%0d_load: got idx=%0d code=%0d expected %0d/%0d", i + 1, step_idx, cur_code, i + 1, codes[i + 1]); end
      end
    end
`ifdef BLINK_SEQ_LOOP_EN
    tests++; if ({busy, step_idx, cur_code} !== {1'b1, 3'd0, 4'd1}) begin fails++; $display("FAIL auto_wrap: got busy=%b idx=%0d code=%0d expected 1/0/1", busy, step_idx, cur_code); end
`else
    tests++; if ({seq_done, busy, led, cur_code} !== {3'b100, 4'd0}) begin fails++; $display("FAIL auto_done: got done=%b busy=%b led=%b code=%0d expected 1/0/0/0", seq_done, busy, led, cur_code); end
`endif
  endtask

  task automatic test_done_restart();
`ifndef BLINK_SEQ_LOOP_EN
    pulse_start();
    tests++; if ({busy, seq_done, step_idx} !== {2'b10, 3'd0}) begin fails++; $display("FAIL done_restart: got busy=%b done=%b idx=%0d expected 1/0/0", busy, seq_done, step_idx); end
`endif
  endtask

  task automatic test_start_stop();
    repeat (65) @(negedge clk);
    tests++; if (led !== 1'b1) begin fails++; $display("FAIL ss_pre_led: got %b expected 1", led); end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    tests++; if ({busy, led, seq_done, cur_code} !== 7'd0) begin fails++; $display("FAIL ss_stop_wins: got busy=%b led=%b done=%b code=%0d expected 0/0/0/0", busy, led, seq_done, cur_code); end
  endtask

  task automatic test_skip_step();
    int n;
    seq_we = 1'b1; seq_addr = 3'd2; seq_data = 4'd0;
    @(negedge clk);
    seq_we = 1'b0;
    pulse_start();
    wait_step(n);
    tests++; if (n !== 120) begin fails++; $display("FAIL skip_step0_len: got %0d expected 120", n); end
    wait_step(n);
    tests++; if (n !== 60) begin fails++; $display("FAIL skip_step1_len: got %0d expected 60", n); end
    tests++; if ({step_idx, cur_code, led} !== {3'd2, 4'd0, 1'b0}) begin fails++; $display("FAIL skip_step2: got idx=%0d code=%0d led=%b expected 2/0/0", step_idx, cur_code, led); end
    wait_step(n);
    tests++; if (n !== 1) begin fails++; $display("FAIL skip_step2_len: got %0d expected 1", n); end
    tests++; if ({step_idx, cur_code} !== {3'd3, 4'd8}) begin fails++; $display("FAIL skip_step3: got idx=%0d code=%0d expected 3/8", step_idx, cur_code); end
    stop = 1'b1; seq_we = 1'b1; seq_addr = 3'd2; seq_data = 4'd4;
    @(negedge clk);
    stop = 1'b0; seq_we = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    pulse_start();
    seq_we = 1'b1; seq_addr = 3'd0; seq_data = 4'd2;
    @(negedge clk);
    seq_we = 1'b0;
    tests++; if (cur_code !== 4'd1) begin fails++; $display("FAIL active_write: got %0d expected 1", cur_code); end
    repeat (3) wait_step(n);
    tests++; if (step_idx !== 3'd3) begin fails++; $display("FAIL rst_reach_step3: got %0d expected 3", step_idx); end
    repeat (9) @(negedge clk);
    tests++; if ({busy, led} !== 2'b11) begin fails++; $display("FAIL rst_pre: got busy=%b led=%b expected 1/1", busy, led); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({led, busy, seq_done, step_idx, cur_code} !== 10'd0) begin fails++; $display("FAIL rst_async: got led=%b busy=%b done=%b idx=%0d code=%0d expected all 0", led, busy, seq_done, step_idx, cur_code); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if ({busy, seq_done, cur_code} !== 6'd0) begin fails++; $display("FAIL rst_idle: got busy=%b done=%b code=%0d expected 0/0/0", busy, seq_done, cur_code); end
    pulse_start();
    tests++; if (cur_code !== 4'd1) begin fails++; $display("FAIL rst_mem_init: got %0d expected 1", cur_code); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_seq();
    test_done_restart();
    test_start_stop();
    test_skip_step();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
